sys_ctrl_host: RTL and testbench



---
 rtl/sys_ctrl_host.sv | 255 +++++++++++++++++++++++++
 tb/tb_sys_ctrl_host.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_host.sv
`default_nettype none
// ============================================================================
// sys_ctrl_host : UART host-side initiator for the system-control protocol.
// Optional macro SYS_HOST_RETRY_EN enables retransmission on timeout. Rev 1.0
// ============================================================================
module sys_ctrl_host #(
  parameter int CLKS_PER_BIT   = 87,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRIES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    c_OP_WRITE  = 3'd2;
  localparam logic [2:0]    c_OP_READ   = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  state_t          r_state;
  logic            r_cmd_ready, r_busy, r_tx;
  logic            r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [7:0]      r_rsp_data;
  logic [2:0]      r_op;
  logic [15:0]     r_addr;
  logic [7:0]      r_wdata;
  logic [1:0]      r_byte_idx;
  logic [3:0]      r_bit_idx;
  logic [CW-1:0]   r_tx_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [7:0]      w_cur_byte;
  logic [1:0]      w_last_idx;

  rx_state_t       r_rx_state;
  logic            r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_sh, r_rx_byte;
  logic            r_rx_done;

`ifdef SYS_HOST_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0]   r_retry;
`else
  logic            w_unused_retry_cfg;
  assign w_unused_retry_cfg = (MAX_RETRIES != 0);
`endif

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign uart_tx     = r_tx;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

  // Byte index 0 is always the opcode; READ stops after the address, WRITE adds data.
  always_comb begin
    w_cur_byte = {5'b0, r_op};
    case (r_byte_idx)
      2'd1:    w_cur_byte = r_addr[15:8];
      2'd2:    w_cur_byte = r_addr[7:0];
      2'd3:    w_cur_byte = r_wdata;
      default: w_cur_byte = {5'b0, r_op};
    endcase
    w_last_idx = 2'd0;
    if (r_op == c_OP_WRITE)     w_last_idx = 2'd3;
    else if (r_op == c_OP_READ) w_last_idx = 2'd2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_tx          <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_op          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_byte_idx    <= '0;
      r_bit_idx     <= '0;
      r_tx_cnt      <= '0;
      r_to_cnt      <= '0;
`ifdef SYS_HOST_RETRY_EN
      r_retry       <= '0;
`endif
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SEND;
            r_tx        <= 1'b0;
            r_tx_cnt    <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
`ifdef SYS_HOST_RETRY_EN
            r_retry     <= '0;
`endif
          end
        end
        S_SEND: begin
          // bit index: 0 start, 1..8 data LSB first, 9 stop
          if (r_tx_cnt == c_BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_bit_idx == 4'd9) begin
              if (r_byte_idx == w_last_idx) begin
                r_state  <= S_WAIT;
                r_to_cnt <= '0;
                r_tx     <= 1'b1;
              end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_bit_idx  <= '0;
                r_tx       <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : w_cur_byte[r_bit_idx[2:0]];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // A byte landing on the expiry cycle wins over the timeout.
          if (r_rx_done) begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx_byte;
            r_rsp_err   <= (r_op != c_OP_READ) && (r_rx_byte != 8'h00);
          end else if (r_to_cnt == c_TO_LAST) begin
`ifdef SYS_HOST_RETRY_EN
            if (r_retry < RW'(MAX_RETRIES)) begin
              r_retry    <= r_retry + 1'b1;
              r_state    <= S_SEND;
              r_tx       <= 1'b0;
              r_tx_cnt   <= '0;
              r_bit_idx  <= '0;
              r_byte_idx <= '0;
            end else begin
              r_state       <= S_DONE;
              r_rsp_valid   <= 1'b1;
              r_rsp_timeout <= 1'b1;
            end
`else
            r_state       <= S_DONE;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Receiver: r_rx_s1/s2 synchronize, r_rx_s3 is edge history for start detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_byte  <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_s3   <= r_rx_s2;
      r_rx_done <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_state <= R_START;
            r_rx_cnt   <= '0;
          end
        end
        R_START: begin
          if (r_rx_cnt == c_HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? R_IDLE : R_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= R_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= R_IDLE;
            if (r_rx_s2) begin
              r_rx_done <= 1'b1;
              r_rx_byte <= r_rx_sh;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_host.sv
`default_nettype none
// tb_sys_ctrl_host : scoreboard bench for sys_ctrl_host (CLKS_PER_BIT=4).
module tb_sys_ctrl_host;

  localparam int CPB  = 4;
  localparam int TO   = 128;
  localparam int BITC = 10 * CPB;
`ifdef SYS_HOST_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        uart_rx = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, uart_tx;
  logic [7:0]  rsp_data;

  sys_ctrl_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int accept_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst && cmd_valid && cmd_ready) accept_cyc <= cyc;

  typedef struct packed {logic [7:0] data; logic err; logic to;} rsp_t;
  rsp_t       exp_rsp[$];
  logic [7:0] exp_tx[$];
  int         tx_starts[$];
  int checks = 0, failures = 0;
  int rsp_count = 0, rsp_cyc = 0, tx_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input logic [7:0] d, input logic e, input logic t);
    rsp_t r;
    r.data = d; r.err = e; r.to = t;
    exp_rsp.push_back(r);
  endtask

  function automatic int nbytes(input logic [2:0] op);
    return (op == 3'd2) ? 4 : (op == 3'd3) ? 3 : 1;
  endfunction

  // Response monitor: pops the scoreboard on every rsp_valid cycle.
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rsp_valid === 1'b1) begin
        rsp_count++;
        rsp_cyc = cyc;
        chk("rsp_vs_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: got rsp_data 0x%0h with nothing pending", rsp_data);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
        end
      end
    end
  end

  // TX monitor: decodes uart_tx frames at mid-bit; frames cut by reset are dropped.
  initial begin : tx_mon
    logic [7:0] b;
    logic       ab, sb;
    int         st;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && uart_tx === 1'b0) begin
        st = cyc; ab = 1'b0;
        repeat (CPB / 2) begin @(negedge clk); if (rst !== 1'b1) ab = 1'b1; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (rst !== 1'b1) ab = 1'b1; end
          b[i] = uart_tx;
        end
        repeat (CPB) begin @(negedge clk); if (rst !== 1'b1) ab = 1'b1; end
        sb = uart_tx;
        if (!ab) begin
          tx_frames++;
          tx_starts.push_back(st);
          chk("tx_stop_bit", {31'b0, sb}, 32'd1);
          if (exp_tx.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: got byte 0x%0h with nothing pending", b);
          end else begin
            chk("tx_byte", {24'b0, b}, {24'b0, exp_tx.pop_front()});
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [7:0] d, input int att);
    int guard;
    logic [7:0] bytes [4];
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    bytes[0] = {5'b0, op}; bytes[1] = a[15:8]; bytes[2] = a[7:0]; bytes[3] = d;
    for (int k = 0; k < att; k++)
      for (int j = 0; j < nbytes(op); j++) exp_tx.push_back(bytes[j]);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_low_after_accept", {31'b0, cmd_ready}, 32'd0);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_tx(input int target);
    int guard;
    guard = 0;
    while (tx_frames < target && guard < 3000) begin @(negedge clk); guard++; end
    if (tx_frames < target) begin
      checks++; failures++;
      $display("FAIL tx_wait: got %0d frames expected %0d", tx_frames, target);
    end
  endtask

  task automatic wait_rsp(input int rc);
    int guard;
    guard = 0;
    while (rsp_count == rc && guard < 2000) begin @(negedge clk); guard++; end
    if (rsp_count == rc) begin
      checks++; failures++;
      $display("FAIL rsp_wait: got no rsp_valid expected one");
    end
    repeat (2) @(negedge clk);
  endtask

  // Start of attempt a, byte k: one cycle after accept, frames contiguous.
  task automatic check_starts(input int n, input int att);
    chk("tx_frame_count", tx_starts.size(), n * att);
    for (int a = 0; a < att; a++)
      for (int k = 0; k < n; k++)
        if (a * n + k < tx_starts.size())
          chk("tx_start_cycle", tx_starts[a * n + k] - accept_cyc, 1 + a * (BITC * n + TO) + BITC * k);
    tx_starts.delete();
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stopb);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (CPB) @(negedge clk); end
    uart_rx = stopb;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] resp, input logic bad_first, input logic stray,
                        input logic exp_err);
    int base, rc;
    base = tx_frames; rc = rsp_count;
    push_rsp(resp, exp_err, 1'b0);
    issue(op, a, d, 1);
    if (stray) rx_byte(8'h7F, 1'b1);
    wait_tx(base + nbytes(op));
    repeat (2) @(negedge clk);
    if (bad_first) rx_byte(resp, 1'b0);
    rx_byte(resp, 1'b1);
    wait_rsp(rc);
    check_starts(nbytes(op), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base, rc;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", {24'b0, rsp_data}, 32'd0);
    chk("reset_rsp_flags", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    chk("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_cmd(3'd5, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);  // PING
    do_cmd(3'd2, 16'h1234, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);  // WRITE
    do_cmd(3'd3, 16'h8000, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0);  // READ, bad frame first

    // HALT with no response: timeout after every attempt
    rc = rsp_count;
    push_rsp(8'h00, 1'b0, 1'b1);
    issue(3'd0, 16'h0000, 8'h00, ATT);
    wait_rsp(rc);
    chk("timeout_latency", rsp_cyc - accept_cyc, 1 + ATT * (BITC + TO));
    check_starts(1, ATT);

    // Stray bytes in IDLE and SEND are ignored
    rc = rsp_count;
    rx_byte(8'h7F, 1'b1);
    repeat (10) @(negedge clk);
    chk("stray_idle_no_rsp", rsp_count, rc);
    do_cmd(3'd2, 16'h0001, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0);  // WRITE with stray during SEND
    do_cmd(3'd1, 16'h0000, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);  // RESUME, nonzero ack

    // Reset in the middle of the second WRITE byte
    base = tx_frames; rc = rsp_count;
    issue(3'd2, 16'hBEEF, 8'h11, 1);
    wait_tx(base + 1);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("midreset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    repeat (8) @(negedge clk);
    exp_tx.delete();
    rst = 1'b1;
    repeat (60) @(negedge clk);
    tx_starts.delete();
    chk("midreset_no_rsp", rsp_count, rc);
    do_cmd(3'd5, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);  // PING after reset

    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
